display_scan_capture: RTL and testbench

Receive side of the multiplexed 7-segment scan interface. It samples the anode and segment lines that the display driver produces, waits for each digit dwell to settle, and decodes the segment pattern back to a 4-bit hex code. It rebuilds an 8-digit frame and reports when every digit position has been refreshed. It is used on a monitor board or in loopback to check what the display driver is actually showing.

---
 rtl/seg_pkg.sv | 54 +++++
 rtl/display_scan_capture_if.sv | 11 +
 rtl/display_scan_capture_sync.sv | 60 ++++++
 rtl/display_scan_capture.sv | 142 ++++++++++++++
 tb/tb_display_scan_capture.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan capture path.
// Holds the active-low hex glyph set (bit0 = segment A ... bit6 = segment G),
// the glyph decoder, an anode one-hot check and the frame FSM state type.
// The display driver uses the same glyph constants, so encode and decode
// always agree.
package seg_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // GLYPHS[k] is the pattern for hex value k.
  localparam logic [15:0][6:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    LOCKED
  } frame_state_t;

  // Returns {known, code}; unknown patterns give 5'b0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    for (int k = 0; k < 16; k++) begin
      if (GLYPHS[k] == seg) r = {1'b1, 4'(k)};
    end
    return r;
  endfunction

  // True when exactly one anode line is low.
  function automatic logic is_one_hot_low(input logic [7:0] an);
    logic [7:0] sel;
    sel = ~an;
    return (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
  endfunction

endpackage

// File: rtl/display_scan_capture_if.sv
// Multiplexed 7-segment scan bus.
//   AN  [7:0] anode lines, active-low, one digit selected at a time
//   SEG [6:0] segment lines, active-low, bit0 = A .. bit6 = G
// master: the display driver side; slave: the capture side.
interface display_scan_capture_if;
  logic [7:0] AN;
  logic [6:0] SEG;

  modport master (output AN, SEG);
  modport slave  (input AN, SEG);
endinterface

// File: rtl/display_scan_capture_sync.sv
// scan_sync_stable: synchronizes the scan bus and accepts a dwell once the
// synchronized value has held still long enough.
//   clk, reset      clock, asynchronous active-low reset
//   an, seg         raw scan pins
//   acc_an, acc_seg settled dwell value, meaningful while accept is high
//   accept          one-clock strobe, once per settled dwell
module scan_sync_stable #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] an,
  input  logic [6:0] seg,
  output logic [7:0] acc_an,
  output logic [6:0] acc_seg,
  output logic       accept
);
  localparam int CW = $clog2(STABLE_CYCLES);

  logic [14:0]   meta_reg, sync_reg, prev_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          accept_reg, accept_next;
  logic          changed;

  // prev_reg is last cycle's synchronized value; it stays equal to the
  // settled value during the accept cycle even if the pins have moved on.
  assign changed = (sync_reg != prev_reg);

  always_comb begin
    cnt_next    = cnt_reg;
    accept_next = 1'b0;
    if (changed) begin
      cnt_next = '0;
    end else if (cnt_reg != CW'(STABLE_CYCLES - 1)) begin
      cnt_next    = cnt_reg + 1'b1;
      // Fires only on the step into saturation, so once per dwell.
      accept_next = (cnt_reg == CW'(STABLE_CYCLES - 2));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_reg   <= 15'h7FFF;
      sync_reg   <= 15'h7FFF;
      prev_reg   <= 15'h7FFF;
      cnt_reg    <= '0;
      accept_reg <= 1'b0;
    end else begin
      meta_reg   <= {an, seg};
      sync_reg   <= meta_reg;
      prev_reg   <= sync_reg;
      cnt_reg    <= cnt_next;
      accept_reg <= accept_next;
    end
  end

  assign acc_an  = prev_reg[14:7];
  assign acc_seg = prev_reg[6:0];
  assign accept  = accept_reg;
endmodule

// File: rtl/display_scan_capture.sv
// display_scan_capture: rebuilds the 8-digit frame shown on a multiplexed
// 7-segment display by watching its anode/segment lines.
//   clk, reset   clock, asynchronous active-low reset
//   scan         scan bus (slave side)
//   clear        synchronous clear of frame, digits and error
//   digits       digit i code at [4i+3:4i]
//   digit_valid  bit i: last accepted pattern for digit i was a hex glyph
//   frame_valid  all 8 digits refreshed since the frame was last dropped
//   frame_done   one-clock pulse per completed refresh of all 8 digits
//   error        sticky: a settled dwell had more than one anode low
module display_scan_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                   clk,
  input  logic                   reset,
  display_scan_capture_if.slave  scan,
  input  logic                   clear,
  output logic [31:0]            digits,
  output logic [7:0]             digit_valid,
  output logic                   frame_valid,
  output logic                   frame_done,
  output logic                   error
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_FIRE = TW'(TIMEOUT_CYCLES - 2);

  logic [7:0] acc_an;
  logic [6:0] acc_seg;
  logic       accept;

  scan_sync_stable #(.STABLE_CYCLES(STABLE_CYCLES)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .an      (scan.AN),
    .seg     (scan.SEG),
    .acc_an  (acc_an),
    .acc_seg (acc_seg),
    .accept  (accept)
  );

  frame_state_t  state_reg, state_next;
  logic [31:0]   digits_reg, digits_next;
  logic [7:0]    dvalid_reg, dvalid_next;
  logic [7:0]    seen_reg, seen_next;
  logic          error_reg, error_next;
  logic          done_reg, done_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;

  logic [4:0] dec;
  logic       one_hot, hit_one, hit_multi, timeout;
  logic [7:0] wr_en;

  assign dec       = seg_decode(acc_seg);
  assign one_hot   = is_one_hot_low(acc_an);
  assign hit_one   = accept && one_hot;
  assign hit_multi = accept && !one_hot && (acc_an != 8'hFF);
  // The counter saturates at T_LAST, so this can fire only once per gap.
  assign timeout   = !hit_one && (tcnt_reg == T_FIRE);

  for (genvar gi = 0; gi < 8; gi++) begin : g_wr
    assign wr_en[gi] = hit_one && !acc_an[gi];
  end

  always_comb begin
    state_next  = state_reg;
    digits_next = digits_reg;
    dvalid_next = dvalid_reg;
    seen_next   = seen_reg;
    error_next  = error_reg;
    done_next   = 1'b0;
    tcnt_next   = tcnt_reg;

    if (tcnt_reg != T_LAST) tcnt_next = tcnt_reg + 1'b1;

    if (hit_one) begin
      tcnt_next = '0;
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) begin
          if (dec[4]) digits_next[i*4 +: 4] = dec[3:0];
          dvalid_next[i] = dec[4];
        end
      end
      if ((seen_reg | wr_en) == 8'hFF) begin
        seen_next  = '0;
        done_next  = 1'b1;
        state_next = LOCKED;
      end else begin
        seen_next = seen_reg | wr_en;
        if (state_reg == IDLE) state_next = COLLECT;
      end
    end

    if (hit_multi) error_next = 1'b1;

    if (timeout) begin
      state_next  = IDLE;
      seen_next   = '0;
      dvalid_next = '0;
    end

    // clear overrides any accept or frame completion in the same cycle.
    if (clear) begin
      state_next  = IDLE;
      seen_next   = '0;
      dvalid_next = '0;
      digits_next = '0;
      error_next  = 1'b0;
      done_next   = 1'b0;
      tcnt_next   = T_LAST;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      digits_reg <= '0;
      dvalid_reg <= '0;
      seen_reg   <= '0;
      error_reg  <= 1'b0;
      done_reg   <= 1'b0;
      tcnt_reg   <= T_LAST;
    end else begin
      state_reg  <= state_next;
      digits_reg <= digits_next;
      dvalid_reg <= dvalid_next;
      seen_reg   <= seen_next;
      error_reg  <= error_next;
      done_reg   <= done_next;
      tcnt_reg   <= tcnt_next;
    end
  end

  assign digits      = digits_reg;
  assign digit_valid = dvalid_reg;
  assign frame_valid = (state_reg == LOCKED);
  assign frame_done  = done_reg;
  assign error       = error_reg;
endmodule

// File: tb/tb_display_scan_capture.sv
module tb_display_scan_capture;
  localparam int S = 16;
  localparam int T = 2048;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_valid, frame_done, error;

  display_scan_capture_if scan();

  display_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan        (scan),
    .clear       (clear),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .frame_done  (frame_done),
    .error       (error)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  int done_pulses = 0;
  int fv_fall_edge = -1;
  logic prev_fv = 1'b0;

  // Behavioural model: a dwell is a run of S identical pin samples; its
  // effect becomes visible three edges after the S-th sample.
  typedef struct {
    int         e;
    logic [7:0] an;
    logic [6:0] seg;
  } pend_t;
  pend_t       pq[$];
  logic [3:0]  m_dig [8];
  logic [7:0]  m_dv, m_seen;
  bit          m_locked, m_err, m_done, m_have_acc;
  int          m_last_acc;
  logic [14:0] m_last;
  int          m_run;

  function automatic void model_reset();
    pq.delete();
    for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
    m_dv = 8'h00; m_seen = 8'h00;
    m_locked = 0; m_err = 0; m_done = 0; m_have_acc = 0; m_last_acc = 0;
    m_last = 15'h7FFF; m_run = S;
  endfunction

  function automatic void model_step(input int e, input logic [7:0] pin_an,
                                     input logic [6:0] pin_seg, input logic clr);
    bit acc;
    logic [7:0] a;
    logic [6:0] sg;
    int idx;
    bit known;
    logic [3:0] code;
    acc = 0; a = 8'hFF; sg = 7'h7F;
    m_done = 0;
    if (pq.size() > 0 && pq[0].e == e) begin
      acc = 1; a = pq[0].an; sg = pq[0].seg;
      pq.delete(0);
    end
    if ({pin_an, pin_seg} == m_last) m_run++;
    else begin
      m_last = {pin_an, pin_seg};
      m_run = 1;
    end
    if (m_run == S) pq.push_back('{e + 3, pin_an, pin_seg});

    if (acc && $countones(~a) == 1) begin
      idx = 0;
      for (int i = 0; i < 8; i++) if (!a[i]) idx = i;
      known = 0; code = 4'h0;
      for (int k = 0; k < 16; k++) if (glyph[k] == sg) begin known = 1; code = 4'(k); end
      if (known) m_dig[idx] = code;
      m_dv[idx] = known;
      m_seen[idx] = 1'b1;
      m_have_acc = 1; m_last_acc = e;
      if (m_seen == 8'hFF) begin
        m_done = 1; m_locked = 1; m_seen = 8'h00;
      end
    end else if (acc && $countones(~a) >= 2) begin
      m_err = 1;
    end
    if (m_have_acc && (e - m_last_acc) == T - 1) begin
      m_locked = 0; m_seen = 8'h00; m_dv = 8'h00;
    end
    if (clr) begin
      for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
      m_dv = 8'h00; m_seen = 8'h00;
      m_locked = 0; m_err = 0; m_done = 0; m_have_acc = 0;
    end
  endfunction

  // Compare process: advance the model on every edge and check all outputs.
  always @(posedge clk) begin : cmp
    logic [31:0] exp_d;
    edge_cnt++;
    if (!reset) model_reset();
    else model_step(edge_cnt, scan.AN, scan.SEG, clear);
    #1;
    for (int i = 0; i < 8; i++) exp_d[4*i +: 4] = m_dig[i];
    tests++;
    if ({digits, digit_valid, frame_valid, frame_done, error} !==
        {exp_d, m_dv, m_locked, m_done, m_err}) begin
      fails++;
      $display("FAIL cycle_compare edge %0d: got digits=%h dv=%h fv=%b fd=%b err=%b, expected digits=%h dv=%h fv=%b fd=%b err=%b",
               edge_cnt, digits, digit_valid, frame_valid, frame_done, error,
               exp_d, m_dv, m_locked, m_done, m_err);
    end
    if (frame_done === 1'b1) done_pulses++;
    if (reset && prev_fv && !frame_valid) fv_fall_edge = edge_cnt;
    prev_fv = frame_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  task automatic dwell(input logic [7:0] an, input logic [6:0] seg, input int n);
    scan.AN = an;
    scan.SEG = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_frame(input int len, output int last_start);
    logic [7:0] a;
    last_start = 0;
    for (int i = 0; i < 8; i++) begin
      a = ~(8'h01 << i);
      last_start = edge_cnt + 1;
      dwell(a, glyph[i], len);
    end
  endtask

  initial begin : stim
    int t0;
    int dp;
    logic [7:0] a;
    logic [6:0] sg;
    int i1, i2;
    scan.AN = 8'hFF;
    scan.SEG = 7'h7F;
    repeat (4) @(negedge clk);
    check("reset_digits", digits, 32'h0);
    check("reset_flags", {21'b0, digit_valid, frame_valid, frame_done, error}, 32'h0);
    reset = 1'b1;
    dwell(8'hFF, 7'h7F, 10);

    // Full frame, 640 clocks per dwell.
    scan_frame(640, t0);
    dwell(8'hFF, 7'h7F, 20);
    check("frame0_digits", digits, 32'h76543210);
    check("frame0_valid", {24'b0, digit_valid}, 32'hFF);
    check("frame0_fv", {31'b0, frame_valid}, 32'h1);
    check("frame0_done_pulses", done_pulses, 1);

    // 'A' on digit 3, unknown pattern on digit 5.
    dwell(8'hF7, 7'h08, 640);
    dwell(8'hDF, 7'h2A, 640);
    dwell(8'hFF, 7'h7F, 20);
    check("glyph_a_code", {28'b0, digits[15:12]}, 32'hA);
    check("glyph_a_valid", {31'b0, digit_valid[3]}, 32'h1);
    check("unknown_valid", {31'b0, digit_valid[5]}, 32'h0);
    check("unknown_kept", {28'b0, digits[23:20]}, 32'h5);

    // One clock too short: nothing written.
    dwell(8'hFE, glyph[9], S - 1);
    dwell(8'hFF, 7'h7F, 40);
    check("short_dwell", {28'b0, digits[3:0]}, 32'h0);

    // Write latency: pins change, first sampled at edge t, visible after t+S+2.
    scan.AN = 8'hFE;
    scan.SEG = glyph[9];
    repeat (S + 2) @(posedge clk);
    #3 check("latency_early", {28'b0, digits[3:0]}, 32'h0);
    @(posedge clk);
    #3 check("latency_write", {28'b0, digits[3:0]}, 32'h9);
    @(negedge clk);
    dwell(8'hFE, glyph[9], 20);
    dwell(8'hFF, 7'h7F, 20);

    // Two anodes low: error, no write; then clear.
    dwell(8'hFC, glyph[8], 40);
    dwell(8'hFF, 7'h7F, 10);
    check("multi_error", {31'b0, error}, 32'h1);
    check("multi_nowrite", digits, 32'h7654A219);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    check("clear_error", {31'b0, error}, 32'h0);
    check("clear_digits", digits, 32'h0);
    check("clear_fv", {31'b0, frame_valid}, 32'h0);

    // Timeout after a full frame, then resume.
    scan_frame(100, t0);
    check("frame1_done_pulses", done_pulses, 2);
    fv_fall_edge = -1;
    dwell(8'hFF, 7'h7F, T + 40);
    check("timeout_fv", {31'b0, frame_valid}, 32'h0);
    check("timeout_dv", {24'b0, digit_valid}, 32'h0);
    check("timeout_digits", digits, 32'h76543210);
    check("timeout_edge", 32'(fv_fall_edge - (t0 + S + 2)), 32'(T - 1));
    scan_frame(100, t0);
    dwell(8'hFF, 7'h7F, 20);
    check("resume_done_pulses", done_pulses, 3);
    check("resume_fv", {31'b0, frame_valid}, 32'h1);

    // Randomized dwells, glitches, multi-anode patterns and clears.
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) a = ~(8'h01 << $urandom_range(0, 7));
      else if (r < 92) a = 8'hFF;
      else begin
        i1 = $urandom_range(0, 7);
        i2 = (i1 + 1 + $urandom_range(0, 6)) % 8;
        a = ~((8'h01 << i1) | (8'h01 << i2));
      end
      if ($urandom_range(0, 9) < 8) sg = glyph[$urandom_range(0, 15)];
      else sg = 7'($urandom);
      if ($urandom_range(0, 49) == 0) clear = 1'b1;
      scan.AN = a;
      scan.SEG = sg;
      @(negedge clk);
      clear = 1'b0;
      repeat ($urandom_range(0, 3 * S)) @(negedge clk);
    end
    $display("[TB] random phase done, %0d frame_done pulses so far", done_pulses);

    // Asynchronous reset in the middle of a frame.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    dwell(8'hFF, 7'h7F, 20);
    for (int i = 0; i < 4; i++) begin
      a = ~(8'h01 << i);
      dwell(a, glyph[i], 100);
    end
    scan.AN = 8'hEF;
    scan.SEG = glyph[4];
    repeat (50) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_reset_digits", digits, 32'h0);
    check("async_reset_flags", {21'b0, digit_valid, frame_valid, frame_done, error}, 32'h0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    dp = done_pulses;
    for (int i = 4; i < 8; i++) begin
      a = ~(8'h01 << i);
      dwell(a, glyph[i], 100);
    end
    dwell(8'hFF, 7'h7F, 20);
    check("after_reset_partial_fv", {31'b0, frame_valid}, 32'h0);
    check("after_reset_no_done", done_pulses, dp);
    scan_frame(100, t0);
    dwell(8'hFF, 7'h7F, 20);
    check("after_reset_full_fv", {31'b0, frame_valid}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
